// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit buffer; allocates slots at decode, completes out of order, retires at head.
module reorder_buffer #(
  parameter int ENTRIES = 8,
  parameter int ID_W    = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_en,
  output logic [ID_W-1:0]   tail,
  output logic              full,
  output logic              empty,
  input  logic              wb_valid,
  input  logic [ID_W-1:0]   wb_slot_id,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              wb_we,
  input  logic              wb_exception,
  input  logic [15:0]       wb_pc,
  output logic              commit_valid,
  output logic              commit_we,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [DATA_W-1:0] commit_result,
  output logic              exc_flush,
  output logic [15:0]       exc_pc
);
  localparam int CW = ID_W + 1;
  logic [ENTRIES-1:0] allocQ, doneQ;
  logic [ADDR_W-1:0]  addrQ   [ENTRIES];
  logic [DATA_W-1:0]  resultQ [ENTRIES];
  logic [15:0]        pcQ     [ENTRIES];
  logic [ENTRIES-1:0] weQ, excQ;
  logic [ID_W-1:0]    head;
  logic [CW-1:0]      count;
  logic               retire, retireExc, allocOk, wbOk;
  assign full      = count == CW'(ENTRIES);
  assign empty     = count == '0;
  assign retire    = allocQ[head] & doneQ[head];
  assign retireExc = retire & excQ[head];
  // a retiring exception squashes anything arriving in the same cycle
  assign allocOk   = alloc_en & ~full & ~retireExc;
  assign wbOk      = wb_valid & allocQ[wb_slot_id] & ~doneQ[wb_slot_id] & ~retireExc;
  always_ff @(posedge clk) begin
    if (wbOk) begin
      addrQ[wb_slot_id]   <= wb_addr;
      resultQ[wb_slot_id] <= wb_result;
      pcQ[wb_slot_id]     <= wb_pc;
      weQ[wb_slot_id]     <= wb_we;
      excQ[wb_slot_id]    <= wb_exception;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      allocQ        <= '0;
      doneQ         <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      commit_valid  <= 1'b0;
      commit_we     <= 1'b0;
      commit_addr   <= '0;
      commit_result <= '0;
      exc_flush     <= 1'b0;
      exc_pc        <= '0;
    end else begin
      commit_valid  <= retire;
      commit_we     <= retire & weQ[head] & ~excQ[head];
      commit_addr   <= retire ? addrQ[head] : '0;
      commit_result <= retire ? resultQ[head] : '0;
      exc_flush     <= retireExc;
      exc_pc        <= retireExc ? pcQ[head] : '0;
      if (retireExc) begin
        allocQ <= '0;
        doneQ  <= '0;
        head   <= tail;
        count  <= '0;
      end else begin
        if (allocOk) begin
          allocQ[tail] <= 1'b1;
          doneQ[tail]  <= 1'b0;
          tail         <= tail + 1'b1;
        end
        if (wbOk) doneQ[wb_slot_id] <= 1'b1;
        if (retire) begin
          allocQ[head] <= 1'b0;
          doneQ[head]  <= 1'b0;
          head         <= head + 1'b1;
        end
        count <= count + CW'(allocOk) - CW'(retire);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed vectors with hand-computed expectations for reorder_buffer.
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alloc_en = 1'b0;
  logic [2:0]  tail;
  logic        full, empty;
  logic        wb_valid = 1'b0;
  logic [2:0]  wb_slot_id = '0;
  logic [2:0]  wb_addr = '0;
  logic [15:0] wb_result = '0;
  logic        wb_we = 1'b0;
  logic        wb_exception = 1'b0;
  logic [15:0] wb_pc = '0;
  logic        commit_valid, commit_we, exc_flush;
  logic [2:0]  commit_addr;
  logic [15:0] commit_result, exc_pc;
  int total = 0;
  int bad = 0;

  reorder_buffer dut (
    .clk(clk), .reset(reset), .alloc_en(alloc_en), .tail(tail), .full(full), .empty(empty),
    .wb_valid(wb_valid), .wb_slot_id(wb_slot_id), .wb_addr(wb_addr), .wb_result(wb_result),
    .wb_we(wb_we), .wb_exception(wb_exception), .wb_pc(wb_pc),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_addr(commit_addr),
    .commit_result(commit_result), .exc_flush(exc_flush), .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic doAlloc();
    alloc_en = 1'b1;
    step();
    alloc_en = 1'b0;
  endtask

  task automatic doWb(input logic [2:0] id, input logic [2:0] a, input logic [15:0] r,
                      input logic we, input logic ex, input logic [15:0] pc);
    wb_valid = 1'b1; wb_slot_id = id; wb_addr = a; wb_result = r;
    wb_we = we; wb_exception = ex; wb_pc = pc;
    step();
    wb_valid = 1'b0; wb_exception = 1'b0;
  endtask

  initial begin
    #2;
    check("rst tail", tail, 0);
    check("rst full", full, 0);
    check("rst empty", empty, 1);
    check("rst cvalid", commit_valid, 0);
    check("rst flush", exc_flush, 0);
    check("rst excpc", exc_pc, 0);
    reset = 1'b1;
    step();

    // single op
    doAlloc();
    check("s tail", tail, 1);
    doWb(0, 3, 16'h1234, 1, 0, 0);
    check("s nocommit", commit_valid, 0);
    step();
    check("s cvalid", commit_valid, 1);
    check("s cwe", commit_we, 1);
    check("s caddr", commit_addr, 3);
    check("s cres", commit_result, 16'h1234);
    step();
    check("s cvalid off", commit_valid, 0);
    check("s empty", empty, 1);
    check("s tail2", tail, 1);

    // out-of-order completion
    doReset();
    repeat (3) doAlloc();
    check("o tail", tail, 3);
    doWb(2, 4, 16'h000c, 1, 0, 0);
    step();
    check("o no commit id2", commit_valid, 0);
    doWb(0, 1, 16'h000a, 1, 0, 0);
    doWb(1, 2, 16'h000b, 1, 0, 0);
    check("o c0 valid", commit_valid, 1);
    check("o c0 addr", commit_addr, 1);
    check("o c0 res", commit_result, 16'h000a);
    step();
    check("o c1 valid", commit_valid, 1);
    check("o c1 addr", commit_addr, 2);
    check("o c1 res", commit_result, 16'h000b);
    step();
    check("o c2 valid", commit_valid, 1);
    check("o c2 addr", commit_addr, 4);
    check("o c2 res", commit_result, 16'h000c);
    step();
    check("o done", commit_valid, 0);
    check("o empty", empty, 1);

    // full and wrap
    doReset();
    repeat (8) doAlloc();
    check("f full", full, 1);
    check("f tail", tail, 0);
    doAlloc();
    check("f 9th tail", tail, 0);
    check("f 9th full", full, 1);
    check("f 9th empty", empty, 0);
    doWb(0, 5, 16'h0500, 1, 0, 0);
    alloc_en = 1'b1;
    step();
    check("f commit", commit_valid, 1);
    check("f refused tail", tail, 0);
    check("f not full", full, 0);
    step();
    alloc_en = 1'b0;
    check("f accept tail", tail, 1);
    check("f full again", full, 1);
    check("f one commit", commit_valid, 0);

    // exception flush
    doReset();
    repeat (4) doAlloc();
    doWb(1, 5, 16'h0077, 1, 1, 16'h0040);
    step();
    check("e wait", commit_valid, 0);
    doWb(0, 6, 16'h0055, 1, 0, 16'h0010);
    step();
    check("e c0 valid", commit_valid, 1);
    check("e c0 we", commit_we, 1);
    check("e c0 addr", commit_addr, 6);
    check("e c0 flush", exc_flush, 0);
    step();
    check("e c1 valid", commit_valid, 1);
    check("e c1 we", commit_we, 0);
    check("e flush", exc_flush, 1);
    check("e pc", exc_pc, 16'h0040);
    check("e empty", empty, 1);
    check("e tail", tail, 4);
    step();
    check("e flush pulse", exc_flush, 0);
    doWb(2, 1, 16'h0222, 1, 0, 0);
    step();
    check("e stale wb", commit_valid, 0);
    check("e stale empty", empty, 1);
    doAlloc();
    check("e realloc tail", tail, 5);
    doWb(4, 7, 16'h0099, 1, 0, 0);
    step();
    check("e head4 commit", commit_valid, 1);
    check("e head4 addr", commit_addr, 7);

    // illegal write-backs
    doReset();
    repeat (2) doAlloc();
    doWb(5, 2, 16'hdead, 1, 0, 0);
    step();
    check("i unalloc", commit_valid, 0);
    check("i tail", tail, 2);
    doWb(0, 3, 16'h1111, 1, 0, 0);
    doWb(0, 5, 16'h2222, 0, 1, 16'h0bad);
    check("i c valid", commit_valid, 1);
    check("i c we", commit_we, 1);
    check("i c addr", commit_addr, 3);
    check("i c res", commit_result, 16'h1111);
    check("i c flush", exc_flush, 0);
    step();
    check("i no more", commit_valid, 0);
    check("i not empty", empty, 0);

    // async reset mid-run
    doReset();
    repeat (3) doAlloc();
    doWb(0, 2, 16'h0abc, 1, 0, 0);
    step();
    check("a pre commit", commit_valid, 1);
    reset = 1'b0;
    #1;
    check("a cvalid", commit_valid, 0);
    check("a caddr", commit_addr, 0);
    check("a empty", empty, 1);
    check("a tail", tail, 0);
    #2;
    reset = 1'b1;
    doWb(1, 3, 16'h0def, 1, 0, 0);
    step();
    check("a stale", commit_valid, 0);
    check("a stale empty", empty, 1);
    check("a stale tail", tail, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order commit buffer for the five-stage pipeline. Decode allocates one slot per issued instruction and receives the slot id, which travels down the pipeline with the instruction. WB returns results tagged with that id, possibly out of order. The buffer retires completed entries strictly in allocation order, drives the register-file write port in decode, and flushes on an exception at the head.

## Interface
Parameters:
- ENTRIES, 8: number of slots; must be a power of two.
- ID_W, 3: slot id width, log2(ENTRIES).
- DATA_W, 16: result width.
- ADDR_W, 3: destination register address width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- alloc_en  in  1  from decode: allocate the slot at `tail` on this edge.
- tail  out  ID_W  id of the next slot to allocate.
- full  out  1  count == ENTRIES; decode must stall.
- empty  out  1  count == 0.
- wb_valid  in  1  WB result present this cycle.
- wb_slot_id  in  ID_W  slot being completed.
- wb_addr  in  ADDR_W  destination register.
- wb_result  in  DATA_W  result data.
- wb_we  in  1  instruction writes a register.
- wb_exception  in  1  instruction raised an exception.
- wb_pc  in  16  PC of the instruction.
- commit_valid  out  1  one-cycle pulse: the head entry retired.
- commit_we  out  1  register-file write enable (commit_valid & entry we & ~exception).
- commit_addr  out  ADDR_W  register-file write address.
- commit_result  out  DATA_W  register-file write data.
- exc_flush  out  1  one-cycle pulse: exception retired, pipeline must clear.
- exc_pc  out  16  PC of the excepting instruction; valid with exc_flush.

## Operation
- Per slot state:
  - `alloc` bit; `done` bit.
  - Payload: addr, result, we, exception, pc.
- Pointers:
  - head and tail are ID_W bits and wrap modulo ENTRIES.
  - count is ID_W+1 bits.
- Allocation:
  - Takes effect when alloc_en=1 and full=0 (registered full).
  - Sets alloc[tail]=1 and done[tail]=0, then advances tail.
  - alloc_en while full is ignored, with no state change.
- Write-back:
  - Takes effect when wb_valid=1 and alloc[wb_slot_id]=1 and done[wb_slot_id]=0.
  - Stores the payload and sets done.
  - A WB to an unallocated or already-done slot is ignored.
- Commit:
  - Decided each cycle from registered state: if alloc[head] and done[head], retire head.
  - Retiring clears alloc and done, advances head, and registers the commit_* outputs for one cycle.
  - At most one commit per cycle.
- Exception:
  - If the retiring head has exception=1: commit_valid=1, commit_we=0, exc_flush=1, exc_pc=pc[head].
  - All alloc and done bits clear; head <= tail (post-update); count <= 0.
  - Any alloc or WB in the same cycle is discarded.
- count update: count + alloc_accepted − commit; simultaneous alloc and commit leaves count unchanged.
- full and empty are combinational from the registered count.

## Timing
- Reset values:
  - All outputs 0: tail=0, full=0, empty=1, commit_*=0, exc_flush=0, exc_pc=0.
  - head=0, count=0, all alloc and done bits 0.
- Reset asserted mid-operation drops all in-flight entries immediately; a WB arriving after release to a stale id is ignored because alloc=0.
- Latency:
  - WB accepted at edge N sets done.
  - If that slot is head, commit_valid is high in the cycle after edge N+1, one cycle of registered decision.
  - Back-to-back completed entries commit on consecutive cycles.
- Full with commit on the same edge: alloc is still refused, because full is registered; the slot frees for the next cycle.
- WB and commit on the same slot in the same cycle cannot occur, since commit requires done already set.
- Wrap-around: tail and head roll 7→0 with ENTRIES=8; count distinguishes full from empty.

## Test plan
- **Reset then single op:** alloc at tail=0; WB id 0, addr 3, result 16'h1234, we=1 → next cycle commit_valid=1, commit_we=1, commit_addr=3, commit_result=16'h1234; then empty=1, tail=1.
- **Out-of-order completion:** alloc ids 0,1,2; WB order 2,0,1 → commits in order 0,1,2 on three consecutive cycles after id 1's WB; no commit after id 2's WB alone.
- **Full and wrap:**
  - 8 allocs → full=1, tail=0; a 9th alloc_en is ignored, count stays 8.
  - Complete id 0 → one commit, full=0; a further alloc is accepted and tail=1.
- **Exception flush:**
  - Alloc 0..3; WB id 1 with exception=1, pc=16'h0040; WB id 0 normal → commit id 0, then commit_valid=1, commit_we=0, exc_flush=1, exc_pc=16'h0040.
  - After the flush: empty=1, head=tail=4; a WB to id 2 is ignored.
- **Illegal write-backs:** a WB to an unallocated id 5 and a second WB to done id 0 → no state change, no commit, payload of id 0 unchanged.
- **Async reset mid-run:** 3 entries allocated, reset low between edges → outputs 0 and empty=1 immediately; after release, tail=0.
